id_stage_pipe: RTL and testbench

//  Parametrised RISC-V instruction-decode stage with an XLEN-wide register file (RF), write-back bypass,

---
 rtl/id_stage_pipe.sv | 131 +++++++++++++
 tb/tb_id_stage_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RISC-V decode stage with register file, WB bypass, immediate generation,
// load-use stall, flush and a valid/ready output register that refreshes held operands.
module id_stage_pipe #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [XLEN-1:0] out_data1,
    output logic [XLEN-1:0] out_data2,
    output logic [XLEN-1:0] out_imm_ext,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);
    localparam int AW = $clog2(NREG);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    logic [XLEN-1:0] rf [NREG];
    logic [6:0]      opcode;
    logic [4:0]      rs1, rs2, rd, cap_rs1, cap_rs2;
    logic            is_i, is_u, known, bad_idx, uses_rs1, uses_rs2;
    logic            hazard, accept, wr_en, illegal;
    logic [XLEN-1:0] val1, val2, imm;
    logic [31:0]     imm32;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    always_comb begin
        is_i     = opcode == OP_I || opcode == OP_LOAD || opcode == OP_JALR;
        is_u     = opcode == OP_LUI || opcode == OP_AUIPC;
        known    = is_i || is_u || opcode == OP_S || opcode == OP_B || opcode == OP_JAL || opcode == OP_R;
        bad_idx  = int'(rd) >= NREG || int'(rs1) >= NREG || int'(rs2) >= NREG;
        illegal  = !known || bad_idx;
        uses_rs1 = !(is_u || opcode == OP_JAL);
        uses_rs2 = opcode == OP_R || opcode == OP_S || opcode == OP_B;
        hazard   = in_valid && ex_is_load && ex_rd != 5'd0 &&
                   ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2));
        in_ready = !hazard && (!out_valid || out_ready) && !flush;
        accept   = in_valid && in_ready;
        wr_en    = wb_en && wb_rd != 5'd0 && int'(wb_rd) < NREG;
    end

    // Reads of x0 are forced to zero; WB forwarding only when BYPASS is enabled.
    always_comb begin
        val1 = rs1 == 5'd0 ? '0 :
               (BYPASS != 0 && wb_en && wb_rd == rs1) ? wb_data : rf[rs1[AW-1:0]];
        val2 = rs2 == 5'd0 ? '0 :
               (BYPASS != 0 && wb_en && wb_rd == rs2) ? wb_data : rf[rs2[AW-1:0]];
    end

    // Every RV immediate fits in 32 signed bits; widen to XLEN with a signed cast.
    always_comb begin
        imm32 = is_i             ? {{20{inst[31]}}, inst[31:20]} :
                opcode == OP_S   ? {{20{inst[31]}}, inst[31:25], inst[11:7]} :
                opcode == OP_B   ? {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0} :
                is_u             ? {inst[31:12], 12'b0} :
                opcode == OP_JAL ? {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0} :
                                   32'd0;
        imm   = XLEN'($signed(imm32));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            out_rd      <= '0;
            out_func3   <= '0;
            out_func7   <= '0;
            out_data1   <= '0;
            out_data2   <= '0;
            out_imm_ext <= '0;
            out_pc      <= '0;
            out_illegal <= 1'b0;
            cap_rs1     <= '0;
            cap_rs2     <= '0;
        end else begin
            if (wr_en) rf[wb_rd[AW-1:0]] <= wb_data;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid   <= 1'b1;
                out_opcode  <= opcode;
                out_rd      <= rd;
                out_func3   <= inst[14:12];
                out_func7   <= inst[31:25];
                out_data1   <= val1;
                out_data2   <= val2;
                out_imm_ext <= imm;
                out_pc      <= pc;
                out_illegal <= illegal;
                cap_rs1     <= rs1;
                cap_rs2     <= rs2;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end else begin
                // Held bundle: keep operands current with write-back.
                if (wb_en && cap_rs1 != 5'd0 && wb_rd == cap_rs1) out_data1 <= wb_data;
                if (wb_en && cap_rs2 != 5'd0 && wb_rd == cap_rs2) out_data2 <= wb_data;
            end
        end
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed-vector bench for id_stage_pipe (XLEN=64, NREG=32, BYPASS=1).
module tb_id_stage_pipe;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst, in_valid, in_ready, flush, ex_is_load, wb_en;
    logic            out_valid, out_ready, out_illegal;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc, wb_data, out_data1, out_data2, out_imm_ext, out_pc;
    logic [4:0]      ex_rd, wb_rd, out_rd;
    logic [6:0]      out_opcode, out_func7;
    logic [2:0]      out_func3;
    int              vectors = 0;
    int              miscompares = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(XLEN), .NREG(32), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
        .flush(flush), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .wb_en(wb_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_func3(out_func3), .out_func7(out_func7), .out_data1(out_data1),
        .out_data2(out_data2), .out_imm_ext(out_imm_ext), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; ex_is_load = 1'b0; ex_rd = '0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1; inst = '0; pc = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; in_valid = 1'b1; inst = 32'hFFF28313; pc = 64'h40;
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h99;
        step(); step();
        rst = 1'b0;
        idle();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        vectors++; if (out_data1 !== 64'h0) begin miscompares++; $display("FAIL reset_data1: got %h want 0", out_data1); end
        vectors++; if (out_imm_ext !== 64'h0) begin miscompares++; $display("FAIL reset_imm: got %h want 0", out_imm_ext); end
        vectors++; if (out_pc !== 64'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        vectors++; if (out_illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal: got %b want 0", out_illegal); end
    endtask

    task automatic test_wb_read();
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h1234;
        step();
        wb_en = 1'b0;
        in_valid = 1'b1; inst = 32'hFFF28313; pc = 64'h100;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL addi_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        vectors++; if (out_data1 !== 64'h1234) begin miscompares++; $display("FAIL addi_data1: got %h want 1234", out_data1); end
        vectors++; if (out_imm_ext !== 64'hFFFF_FFFF_FFFF_FFFF) begin miscompares++; $display("FAIL addi_imm: got %h want ffffffffffffffff", out_imm_ext); end
        vectors++; if (out_rd !== 5'd6 || out_opcode !== 7'h13 || out_pc !== 64'h100) begin
            miscompares++; $display("FAIL addi_fields: got rd=%0d op=%h pc=%h want rd=6 op=13 pc=100", out_rd, out_opcode, out_pc); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_x0_bypass();
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hDEAD;
        step();
        in_valid = 1'b1; inst = 32'h00000313; pc = 64'h110;
        step();
        vectors++; if (out_data1 !== 64'h0) begin miscompares++; $display("FAIL x0_read: got %h want 0", out_data1); end
        inst = 32'h00038413; pc = 64'h114; wb_rd = 5'd7; wb_data = 64'h55;
        step();
        vectors++; if (out_data1 !== 64'h55) begin miscompares++; $display("FAIL bypass_x7: got %h want 55", out_data1); end
        wb_en = 1'b0; pc = 64'h118;
        step();
        vectors++; if (out_data1 !== 64'h55 || out_pc !== 64'h118) begin
            miscompares++; $display("FAIL rf_x7: got data1=%h pc=%h want 55/118", out_data1, out_pc); end
    endtask

    task automatic test_hazard();
        in_valid = 1'b1; inst = 32'h00728233; pc = 64'h120; ex_is_load = 1'b1; ex_rd = 5'd7;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hazard_ready: got %b want 0", in_ready); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hazard_bubble: got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hazard_retry: got %b want 0", in_ready); end
        ex_is_load = 1'b0;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL hazard_clear: got %b want 1", in_ready); end
        step();
        vectors++; if (out_valid !== 1'b1 || out_data1 !== 64'h1234 || out_data2 !== 64'h55 || out_rd !== 5'd4) begin
            miscompares++; $display("FAIL hazard_accept: got v=%b d1=%h d2=%h rd=%0d want 1/1234/55/4", out_valid, out_data1, out_data2, out_rd); end
        inst = 32'hFFF28313; ex_is_load = 1'b1; ex_rd = 5'd31;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rs2_unused: got %b want 1", in_ready); end
        step();
        idle();
        step();
    endtask

    task automatic test_hold();
        in_valid = 1'b1; inst = 32'h00928533; pc = 64'h200;
        step();
        vectors++; if (out_valid !== 1'b1 || out_data2 !== 64'h0) begin
            miscompares++; $display("FAIL hold_load: got v=%b d2=%h want 1/0", out_valid, out_data2); end
        out_ready = 1'b0; inst = 32'h00000313; pc = 64'h204;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL hold_ready: got %b want 0", in_ready); end
        step();
        vectors++; if (out_data2 !== 64'h0 || out_pc !== 64'h200) begin
            miscompares++; $display("FAIL hold_1: got d2=%h pc=%h want 0/200", out_data2, out_pc); end
        wb_en = 1'b1; wb_rd = 5'd9; wb_data = 64'hAA;
        step();
        wb_en = 1'b0;
        vectors++; if (out_data2 !== 64'hAA) begin miscompares++; $display("FAIL hold_refresh: got %h want aa", out_data2); end
        vectors++; if (out_valid !== 1'b1 || out_data1 !== 64'h1234 || out_rd !== 5'd10 || out_pc !== 64'h200 || out_opcode !== 7'h33) begin
            miscompares++; $display("FAIL hold_stable: got v=%b d1=%h rd=%0d pc=%h op=%h want 1/1234/10/200/33", out_valid, out_data1, out_rd, out_pc, out_opcode); end
        step();
        vectors++; if (out_data2 !== 64'hAA || out_rd !== 5'd10) begin
            miscompares++; $display("FAIL hold_3: got d2=%h rd=%0d want aa/10", out_data2, out_rd); end
        idle();
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; inst = 32'hFFF28313; pc = 64'h300;
        step();
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL flush_pre: got %b want 1", out_valid); end
        flush = 1'b1; inst = 32'h00038413; pc = 64'h304;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        step();
        idle();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_kill: got %b want 0", out_valid); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_noaccept: got %b want 0", out_valid); end
    endtask

    task automatic test_imm();
        logic [31:0] insts [5] = '{32'hFE000EE3, 32'h0040006F, 32'h800000B7, 32'hFE112C23, 32'h0000007F};
        logic [63:0] imms  [5] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h4, 64'hFFFF_FFFF_8000_0000,
                                   64'hFFFF_FFFF_FFFF_FFF8, 64'h0};
        logic        ills  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; inst = insts[k]; pc = 64'h400 + 64'(4 * k);
            step();
            vectors++; if (out_valid !== 1'b1 || out_imm_ext !== imms[k]) begin
                miscompares++; $display("FAIL imm_%0d: got v=%b imm=%h want 1/%h", k, out_valid, out_imm_ext, imms[k]); end
            vectors++; if (out_illegal !== ills[k]) begin
                miscompares++; $display("FAIL illegal_%0d: got %b want %b", k, out_illegal, ills[k]); end
        end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_wb_read();
        test_x0_bypass();
        test_hazard();
        test_hold();
        test_flush();
        test_imm();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
